pattern_pwm_gen: RTL and testbench

Parametrised serial pattern generator for the DDS sample path. It shifts out a latched bit pattern of programmable length, holding each bit for a programmable number of clock cycles, and repeats the pattern N times or indefinitely until stopped. It supports LSB- or MSB-first order, a programmable idle level, and abort. It sits between the control register block and the trigger/marker outputs.

---
 rtl/pattern_pwm_pkg.sv | 13 +
 rtl/pattern_pwm_gen_if.sv | 36 +++
 rtl/pattern_pwm_gen_bit_timer.sv | 30 +++
 rtl/pattern_pwm_gen.sv | 108 ++++++++++
 tb/tb_pattern_pwm_gen.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_pwm_pkg.sv
// pattern_pwm_pkg: shared FSM encoding and default widths for the pattern PWM generator.
package pattern_pwm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_PAT_W  = 16;
    localparam int DEF_DUTY_W = 8;
    localparam int DEF_REP_W  = 8;

endpackage

// File: rtl/pattern_pwm_gen_if.sv
// pattern_pwm_gen_if: control/config inputs and status outputs of the pattern PWM generator.
//   master: drives start, stop, pat, len_m1, duty_num, rep_num, msb_first, idle_level;
//           observes pwm_out, busy, done, aborted.
//   slave:  the generator side, directions reversed.
interface pattern_pwm_gen_if
    import pattern_pwm_pkg::*;
#(
    parameter int PAT_W  = DEF_PAT_W,
    parameter int DUTY_W = DEF_DUTY_W,
    parameter int REP_W  = DEF_REP_W,
    parameter int LEN_W  = $clog2(PAT_W)
);
    logic              start;
    logic              stop;
    logic [PAT_W-1:0]  pat;
    logic [LEN_W-1:0]  len_m1;
    logic [DUTY_W-1:0] duty_num;
    logic [REP_W-1:0]  rep_num;
    logic              msb_first;
    logic              idle_level;
    logic              pwm_out;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        output start, stop, pat, len_m1, duty_num, rep_num, msb_first, idle_level,
        input  pwm_out, busy, done, aborted
    );

    modport slave (
        input  start, stop, pat, len_m1, duty_num, rep_num, msb_first, idle_level,
        output pwm_out, busy, done, aborted
    );

endinterface

// File: rtl/pattern_pwm_gen_bit_timer.sv
// pwm_bit_timer: per-bit hold counter; tick marks the last cycle of the current bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at 0
//   en         : advance the count (wraps to 0 after reaching limit)
//   limit      : last count value of a bit (hold length minus 1)
//   tick       : count equals limit
module pwm_bit_timer #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DUTY_W-1:0] limit,
    output logic              tick
);
    logic [DUTY_W-1:0] cnt;

    assign tick = cnt == limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + DUTY_W'(1);
    end

endmodule

// File: rtl/pattern_pwm_gen.sv
// pattern_pwm_gen: serial pattern generator with per-bit hold, repeat count, bit order and abort.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pattern_pwm_gen_if
//                inputs  start/stop requests and pattern configuration (latched on start)
//                outputs pwm_out (registered serial bit), busy, done and aborted pulses
module pattern_pwm_gen
    import pattern_pwm_pkg::*;
#(
    parameter int PAT_W  = DEF_PAT_W,
    parameter int DUTY_W = DEF_DUTY_W,
    parameter int REP_W  = DEF_REP_W,
    localparam int LEN_W = $clog2(PAT_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pattern_pwm_gen_if.slave        bus
);
    state_t            state, state_nxt;
    logic [PAT_W-1:0]  pat_l;
    logic [LEN_W-1:0]  len_m1_l, bit_cnt, bit_nxt;
    logic [DUTY_W-1:0] duty_num_l;
    logic [REP_W-1:0]  rep_num_l, rep_cnt, rep_nxt;
    logic              msb_l;
    logic              pwm_q, done_q, aborted_q;
    logic              pwm_nxt, done_nxt, aborted_nxt;
    logic              tick, start_ok, bit_wrap, fin;

    function automatic logic pick(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                                  input logic [LEN_W-1:0] b, input logic m);
        return m ? p[l - b] : p[b];
    endfunction

    pwm_bit_timer #(.DUTY_W(DUTY_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (state == ST_RUN),
        .limit (duty_num_l),
        .tick  (tick)
    );

    assign bus.pwm_out = pwm_q;
    assign bus.busy    = state == ST_RUN;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;

    // pwm_out is registered, so the next-cycle bit is chosen from the next bit index;
    // this keeps repeats seamless and puts the first bit out on the start edge.
    always_comb begin
        start_ok    = state == ST_IDLE && bus.start && !bus.stop;
        bit_wrap    = tick && bit_cnt == len_m1_l;
        fin         = bit_wrap && rep_num_l != '0 && rep_cnt + REP_W'(1) == rep_num_l;
        bit_nxt     = tick ? (bit_wrap ? '0 : bit_cnt + LEN_W'(1)) : bit_cnt;
        rep_nxt     = bit_wrap ? rep_cnt + REP_W'(1) : rep_cnt;
        state_nxt   = state;
        pwm_nxt     = bus.idle_level;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        if (state == ST_IDLE) begin
            if (start_ok) begin
                state_nxt = ST_RUN;
                pwm_nxt   = pick(bus.pat, bus.len_m1, '0, bus.msb_first);
            end
        end else if (bus.stop) begin
            state_nxt   = ST_IDLE;
            aborted_nxt = 1'b1;
        end else if (fin) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
        end else begin
            pwm_nxt = pick(pat_l, len_m1_l, bit_nxt, msb_l);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pwm_q      <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            pat_l      <= '0;
            len_m1_l   <= '0;
            duty_num_l <= '0;
            rep_num_l  <= '0;
            msb_l      <= 1'b0;
            bit_cnt    <= '0;
            rep_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            pwm_q     <= pwm_nxt;
            done_q    <= done_nxt;
            aborted_q <= aborted_nxt;
            if (start_ok) begin
                pat_l      <= bus.pat;
                len_m1_l   <= bus.len_m1;
                duty_num_l <= bus.duty_num;
                rep_num_l  <= bus.rep_num;
                msb_l      <= bus.msb_first;
                bit_cnt    <= '0;
                rep_cnt    <= '0;
            end else if (state == ST_RUN) begin
                bit_cnt <= bit_nxt;
                rep_cnt <= rep_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pattern_pwm_gen.sv
// tb_pattern_pwm_gen: scoreboard bench; stimulus queues expected runs, a monitor checks each observed run.
module tb_pattern_pwm_gen;
    localparam int K_DONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RESET = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bit   exp_bits[$];
    int   exp_len[$];
    int   exp_kind[$];
    bit   exp_idle[$];

    pattern_pwm_gen_if bus ();

    pattern_pwm_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected bit at busy cycle t is pattern index (t / hold) mod length, in the selected order.
    task automatic push_run(input logic [15:0] p, input int l, input int d, input bit m,
                            input int len, input int kind, input bit idle);
        for (int t = 0; t < len; t++) begin
            int idx;
            idx = (t / (d + 1)) % (l + 1);
            exp_bits.push_back(m ? p[l - idx] : p[idx]);
        end
        exp_len.push_back(len);
        exp_kind.push_back(kind);
        exp_idle.push_back(idle);
    endtask

    task automatic set_cfg(input logic [15:0] p, input int l, input int d, input int r,
                           input bit m, input bit idle);
        bus.pat        = p;
        bus.len_m1     = 4'(l);
        bus.duty_num   = 8'(d);
        bus.rep_num    = 8'(r);
        bus.msb_first  = m;
        bus.idle_level = idle;
    endtask

    // Returns just after the start edge: the caller is in busy cycle 1.
    task automatic start_run();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic stop_at(input int k);
        repeat (k - 1) @(posedge clk);
        #1 bus.stop = 1'b1;
        @(posedge clk);
        #1 bus.stop = 1'b0;
    endtask

    task automatic wait_end(input string name, input int max);
        int n;
        n = 0;
        while (exp_len.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (exp_len.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout pending_runs=%0d required=0", name, exp_len.size());
            exp_bits.delete();
            exp_len.delete();
            exp_kind.delete();
            exp_idle.delete();
        end
    endtask

    // Monitor: collect pwm_out while busy, judge the run on the cycle busy falls.
    bit prev_busy = 1'b0;
    bit in_run = 1'b0;
    int obs_len = 0;
    int bad_bits = 0;

    always @(negedge clk) begin
        if (bus.busy) begin
            if (!prev_busy) begin
                in_run   = exp_len.size() != 0;
                obs_len  = 0;
                bad_bits = 0;
                if (!in_run) chk("unexpected_run", 32'(bus.busy), 0);
            end
            if (in_run) begin
                if (obs_len < exp_len[0] && exp_bits.size() != 0) begin
                    if (bus.pwm_out !== exp_bits.pop_front()) bad_bits++;
                end else begin
                    bad_bits++;
                end
                obs_len++;
            end
        end else if (prev_busy && in_run) begin
            int len, kind;
            bit idl;
            len  = exp_len.pop_front();
            kind = exp_kind.pop_front();
            idl  = exp_idle.pop_front();
            for (int j = obs_len; j < len; j++)
                if (exp_bits.size() != 0) void'(exp_bits.pop_front());
            chk("run_length", 32'(obs_len), 32'(len));
            chk("run_bits_wrong", 32'(bad_bits), 0);
            chk("end_done", 32'(bus.done), 32'(kind == K_DONE));
            chk("end_aborted", 32'(bus.aborted), 32'(kind == K_ABORT));
            chk("end_level", 32'(bus.pwm_out), kind == K_RESET ? 0 : 32'(idl));
            in_run = 1'b0;
        end else if (bus.done || bus.aborted) begin
            chk("spurious_pulse", {30'd0, bus.done, bus.aborted}, 0);
        end
        prev_busy = bus.busy;
    end

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(16'h0000, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("reset_pwm", 32'(bus.pwm_out), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_aborted", 32'(bus.aborted), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_level_high", 32'(bus.pwm_out), 1);
        bus.idle_level = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_level_low", 32'(bus.pwm_out), 0);

        // 0xA5 LSB-first, 3 cycles per bit, one pass: 24 busy cycles
        set_cfg(16'h00A5, 7, 2, 1, 1'b0, 1'b0);
        push_run(16'h00A5, 7, 2, 1'b0, 24, K_DONE, 1'b0);
        start_run();
        wait_end("a5_lsb", 60);

        // MSB-first, three seamless passes: 72 busy cycles
        set_cfg(16'h00A5, 7, 2, 3, 1'b1, 1'b0);
        push_run(16'h00A5, 7, 2, 1'b1, 72, K_DONE, 1'b0);
        start_run();
        wait_end("a5_msb", 120);

        // 0x0003 MSB-first: 0,0,0,0,0,0,1,1 per pass
        set_cfg(16'h0003, 7, 2, 3, 1'b1, 1'b0);
        push_run(16'h0003, 7, 2, 1'b1, 72, K_DONE, 1'b0);
        start_run();
        wait_end("p03_msb", 120);

        // start re-pulsed mid-run with other config is ignored; start in done cycle is accepted
        set_cfg(16'h00A5, 7, 2, 1, 1'b0, 1'b0);
        push_run(16'h00A5, 7, 2, 1'b0, 24, K_DONE, 1'b0);
        start_run();
        repeat (4) @(posedge clk);
        #1 set_cfg(16'hFFFF, 2, 0, 5, 1'b1, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        push_run(16'h0003, 3, 1, 1'b0, 16, K_DONE, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.done && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("done_seen_for_b2b", 32'(bus.done), 1);
        end
        set_cfg(16'h0003, 3, 1, 2, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_end("back_to_back", 80);

        // endless run kept going past 1000 cycles, then stopped
        set_cfg(16'h0006, 3, 0, 0, 1'b0, 1'b0);
        push_run(16'h0006, 3, 0, 1'b0, 1100, K_ABORT, 1'b0);
        start_run();
        stop_at(1100);
        wait_end("endless_long", 20);

        // endless run stopped in busy cycle 37
        set_cfg(16'h000B, 3, 0, 0, 1'b0, 1'b0);
        push_run(16'h000B, 3, 0, 1'b0, 37, K_ABORT, 1'b0);
        start_run();
        stop_at(37);
        wait_end("stop_37", 20);

        // single-bit pattern, one cycle, idle high: 1,0,1
        set_cfg(16'hFFFE, 0, 0, 1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("idle_before_single", 32'(bus.pwm_out), 1);
        push_run(16'hFFFE, 0, 0, 1'b0, 1, K_DONE, 1'b1);
        start_run();
        wait_end("single_bit", 20);

        // start together with stop in IDLE does nothing
        @(posedge clk);
        #1 begin
            bus.start = 1'b1;
            bus.stop  = 1'b1;
        end
        @(posedge clk);
        #1 begin
            bus.start = 1'b0;
            bus.stop  = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("start_stop_idle_busy", 32'(bus.busy), 0);

        // stop coinciding with natural completion: aborted wins
        set_cfg(16'h0001, 1, 0, 1, 1'b0, 1'b0);
        push_run(16'h0001, 1, 0, 1'b0, 2, K_ABORT, 1'b0);
        start_run();
        stop_at(2);
        wait_end("stop_at_last", 20);

        // asynchronous reset mid-run: no pulses, outputs cleared at once
        set_cfg(16'h00A5, 7, 2, 2, 1'b0, 1'b1);
        push_run(16'h00A5, 7, 2, 1'b0, 9, K_RESET, 1'b1);
        start_run();
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_busy", 32'(bus.busy), 0);
        wait_end("reset_mid", 10);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // normal run after reset release
        set_cfg(16'h00A5, 7, 2, 1, 1'b0, 1'b0);
        push_run(16'h00A5, 7, 2, 1'b0, 24, K_DONE, 1'b0);
        start_run();
        wait_end("after_reset", 60);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_len.size() + exp_bits.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
